// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the miner result path: field widths of the result
// word (nonce followed by hash), the serial symbol width, and the state
// encoding used by result_serializer.
// ---------------------------------------------------------------------------
package miner_pkg;

    localparam int NONCE_W  = 32;
    localparam int HASH_W   = 256;
    localparam int RESULT_W = NONCE_W + HASH_W;
    localparam int BYTE_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ser_state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// ---------------------------------------------------------------------------
// rise_edge_detect
// One-cycle pulse on a rising edge of a level input.
//
// Ports:
//   clk    in   system clock
//   n_rst  in   asynchronous active-low reset
//   in     in   level to watch
//   pulse  out  high for the cycle in which in is 1 and was 0 last cycle
// ---------------------------------------------------------------------------
module rise_edge_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic armed;

    // in_q is the previous-cycle copy of the input. armed only sets once the
    // input has been seen low, so a level that is already high when reset is
    // released is not mistaken for a fresh rising edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            in_q <= in;
            if (!in) begin
                armed <= 1'b1;
            end
        end
    end

    assign pulse = in & ~in_q & armed;

endmodule

// File: rtl/result_serializer.sv
// ---------------------------------------------------------------------------
// result_serializer
// Captures the miner result word on a rising edge of send_data and streams it
// out MSB-first, one byte per valid/ready transfer, to the UART transmitter.
// A rising edge that arrives while a frame is in flight sets a sticky overrun
// flag and is otherwise ignored.
//
// Build option: define CHECKSUM_EN to append one byte after the data bytes
// holding the XOR of all data bytes.
//
// Ports:
//   clk         in   system clock
//   n_rst       in   asynchronous active-low reset
//   send_data   in   result-available strobe (level or pulse)
//   tx_data     in   result word, sampled on the start cycle only
//   byte_ready  in   transmitter can accept a byte
//   byte_out    out  current byte (0 when not valid)
//   byte_valid  out  byte_out is valid
//   busy        out  frame in progress (SEND or DONE)
//   done        out  one-cycle pulse after the last byte is accepted
//   overrun     out  sticky: a result arrived while busy
// ---------------------------------------------------------------------------
module result_serializer #(
    parameter int DATA_W = miner_pkg::RESULT_W,
    parameter int BYTE_W = miner_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              send_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              byte_ready,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    import miner_pkg::*;

    localparam int NUM_BYTES = DATA_W / BYTE_W;
    localparam int CNT_W     = $clog2(NUM_BYTES + 1);

`ifdef CHECKSUM_EN
    localparam int LAST_IDX = NUM_BYTES;
`else
    localparam int LAST_IDX = NUM_BYTES - 1;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);

    ser_state_t        state;
    ser_state_t        next_state;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  count;
    logic              overrun_q;
    logic              start;
    logic              transfer;

`ifdef CHECKSUM_EN
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(NUM_BYTES);
    logic [BYTE_W-1:0] csum;
`endif

    rise_edge_detect u_start_edge (
        .clk   (clk),
        .n_rst (n_rst),
        .in    (send_data),
        .pulse (start)
    );

    assign transfer = (state == SEND) && byte_ready;
    assign overrun  = overrun_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: the word is latched only on a start seen in IDLE, so a late
    // edge or a change of tx_data never disturbs a frame already in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            if (state == IDLE && start) begin
                shift_reg <= tx_data;
                count     <= '0;
`ifdef CHECKSUM_EN
                csum      <= '0;
`endif
            end else if (transfer) begin
                shift_reg <= shift_reg << BYTE_W;
                count     <= count + 1'b1;
`ifdef CHECKSUM_EN
                if (count < DATA_CNT) begin
                    csum <= csum ^ shift_reg[DATA_W-1 -: BYTE_W];
                end
`endif
            end

            if (start && state != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Next state and Moore outputs; byte_out is forced to 0 outside SEND so
    // the link sees a clean zero whenever byte_valid is low.
    always_comb begin
        next_state = state;
        byte_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        byte_out   = '0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                byte_valid = 1'b1;
                busy       = 1'b1;
`ifdef CHECKSUM_EN
                if (count == DATA_CNT) begin
                    byte_out = csum;
                end else begin
                    byte_out = shift_reg[DATA_W-1 -: BYTE_W];
                end
`else
                byte_out   = shift_reg[DATA_W-1 -: BYTE_W];
`endif
                if (transfer && count == LAST_CNT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_result_serializer
// Self-checking bench for result_serializer. Frames are described by a table
// of vectors; each vector gives the word, a repeating 3-cycle byte_ready
// pattern, how long send_data is held, and optional mid-frame events (a
// second start edge or a reset). The expected byte stream is sliced from the
// word MSB-first, with the XOR byte appended when CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module tb_result_serializer;

    localparam int DATA_W    = 288;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = DATA_W / BYTE_W;
`ifdef CHECKSUM_EN
    localparam int FRAME_LEN = NUM_BYTES + 1;
    localparam logic [7:0] LAST_BYTE_S2 = 8'h23;
`else
    localparam int FRAME_LEN = NUM_BYTES;
    localparam logic [7:0] LAST_BYTE_S2 = 8'h01;
`endif

    logic              clk;
    logic              n_rst;
    logic              send_data;
    logic [DATA_W-1:0] tx_data;
    logic              byte_ready;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              busy;
    logic              done;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [2:0]        ready_pat;
        int                hold;
        int                restart_after;
        int                reset_after;
        logic              exp_overrun;
    } vec_t;

    vec_t vecs [5];

    result_serializer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .send_data  (send_data),
        .tx_data    (tx_data),
        .byte_ready (byte_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check_output({tag, "_byte_out"},   32'(byte_out),   32'd0);
        check_output({tag, "_busy"},       32'(busy),       32'd0);
        check_output({tag, "_done"},       32'(done),       32'd0);
        check_output({tag, "_overrun"},    32'(overrun),    32'd0);
    endtask

    // Runs one frame: inputs change #1 after the rising edge, outputs are
    // sampled on the falling edge. last_byte returns the final byte accepted.
    task automatic apply_stimulus(input vec_t v, output logic [7:0] last_byte);
        logic [7:0] exp_bytes [FRAME_LEN];
        logic [7:0] csum;
        logic [7:0] prev_byte;
        logic       prev_stall;
        logic       finished;
        int         idx;
        int         done_cnt;
        int         restart_cyc;

        csum = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            exp_bytes[i] = v.data[DATA_W-1-8*i -: 8];
            csum = csum ^ exp_bytes[i];
        end
`ifdef CHECKSUM_EN
        exp_bytes[NUM_BYTES] = csum;
`endif

        idx         = 0;
        done_cnt    = 0;
        restart_cyc = -1;
        prev_stall  = 1'b0;
        prev_byte   = 8'h00;
        finished    = 1'b0;
        last_byte   = 8'h00;

        @(posedge clk);
        #1;
        send_data = 1'b1;
        tx_data   = v.data;

        for (int c = 0; c < 400 && !finished; c++) begin
            byte_ready = v.ready_pat[c % 3];
            if (c == v.hold) send_data = 1'b0;
            if (restart_cyc >= 0 && c == restart_cyc + 1) send_data = 1'b0;
            if (v.restart_after >= 0 && restart_cyc < 0 && idx == v.restart_after) begin
                send_data   = 1'b1;
                tx_data     = '1;
                restart_cyc = c;
            end
            if (v.reset_after >= 0 && idx == v.reset_after) begin
                n_rst      = 1'b0;
                send_data  = 1'b0;
                byte_ready = 1'b0;
                #1;
                check_all_zero("mid_reset");
                @(posedge clk);
                #1;
                n_rst = 1'b1;
                return;
            end

            @(negedge clk);
            if (c == 0) begin
                check_output("first_cycle_valid", 32'(byte_valid), 32'd0);
            end
            if (c == 1) begin
                check_output("second_cycle_valid", 32'(byte_valid), 32'd1);
            end
            if (restart_cyc >= 0 && c == restart_cyc) begin
                check_output("overrun_before", 32'(overrun), 32'd0);
            end
            if (restart_cyc >= 0 && c == restart_cyc + 1) begin
                check_output("overrun_after", 32'(overrun), 32'd1);
            end
            if (prev_stall) begin
                check_output("stall_valid", 32'(byte_valid), 32'd1);
                check_output("stall_byte",  32'(byte_out),   32'(prev_byte));
            end
            if (byte_valid && byte_ready) begin
                if (idx < FRAME_LEN) begin
                    check_output("byte", 32'(byte_out), 32'(exp_bytes[idx]));
                end else begin
                    check_output("extra_byte", 32'(idx), 32'(FRAME_LEN - 1));
                end
                last_byte = byte_out;
                idx++;
            end
            if (done) begin
                done_cnt++;
                check_output("busy_in_done",  32'(busy), 32'd1);
                check_output("done_position", 32'(idx),  32'(FRAME_LEN));
            end else if (!byte_valid) begin
                check_output("idle_busy", 32'(busy), 32'd0);
            end
            prev_stall = byte_valid && !byte_ready;
            prev_byte  = byte_out;
            if (done_cnt > 0 && c >= v.hold + 2) finished = 1'b1;

            @(posedge clk);
            #1;
        end

        check_output("frame_timeout", 32'(finished), 32'd1);
        send_data  = 1'b0;
        byte_ready = 1'b0;
        @(negedge clk);
        check_output("after_done",       32'(done),       32'd0);
        check_output("after_busy",       32'(busy),       32'd0);
        check_output("after_byte_valid", 32'(byte_valid), 32'd0);
        check_output("transfer_count",   32'(idx),        32'(FRAME_LEN));
        check_output("done_count",       32'(done_cnt),   32'd1);
        check_output("overrun_final",    32'(overrun),    32'(v.exp_overrun));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] s2_data;
        logic [DATA_W-1:0] inc_data;
        logic [7:0]        last_byte;
        vec_t              v;

        s2_data = {32'hDEADBEEF, 255'h0, 1'b1};
        for (int i = 0; i < NUM_BYTES; i++) begin
            inc_data[DATA_W-1-8*i -: 8] = 8'(i);
        end

        vecs[0] = '{data: s2_data, ready_pat: 3'b111, hold: 1, restart_after: -1,
                    reset_after: -1, exp_overrun: 1'b0};
        vecs[1] = '{data: s2_data, ready_pat: 3'b001, hold: 1, restart_after: -1,
                    reset_after: -1, exp_overrun: 1'b0};
        vecs[2] = '{data: s2_data, ready_pat: 3'b111, hold: 100, restart_after: -1,
                    reset_after: -1, exp_overrun: 1'b0};
        vecs[3] = '{data: inc_data, ready_pat: 3'b101, hold: 1, restart_after: -1,
                    reset_after: -1, exp_overrun: 1'b0};
        vecs[4] = '{data: {32'h0BADF00D,
                           256'hFEDC_BA98_7654_3210_0011_2233_4455_6677_8899_AABB_CCDD_EEFF_A5A5_5A5A_C3C3_3C3C},
                    ready_pat: 3'b011, hold: 1, restart_after: -1,
                    reset_after: -1, exp_overrun: 1'b0};

        // Reset held with send_data already high and a nonzero word.
        n_rst      = 1'b0;
        send_data  = 1'b1;
        tx_data    = s2_data;
        byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");

        // Releasing reset with send_data still high must not start a frame.
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("no_start_valid", 32'(byte_valid), 32'd0);
            check_output("no_start_busy",  32'(busy),       32'd0);
        end
        @(posedge clk);
        #1;
        send_data  = 1'b0;
        byte_ready = 1'b0;

        // Table-driven frames.
        for (int n = 0; n < 5; n++) begin
            apply_stimulus(vecs[n], last_byte);
            if (n == 0) check_output("s2_last_byte", 32'(last_byte), 32'(LAST_BYTE_S2));
        end

        // Second start edge after 10 transfers with the word changed to all-FF.
        v = vecs[0];
        v.restart_after = 10;
        v.exp_overrun   = 1'b1;
        apply_stimulus(v, last_byte);
        check_output("overrun_last_byte", 32'(last_byte), 32'(LAST_BYTE_S2));

        // Reset after 20 transfers clears everything including overrun.
        v = vecs[0];
        v.reset_after = 20;
        apply_stimulus(v, last_byte);

        // A fresh edge after the abort produces a complete frame.
        apply_stimulus(vecs[0], last_byte);
        check_output("post_reset_last_byte", 32'(last_byte), 32'(LAST_BYTE_S2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
